tdc_fine_encoder_pipe: RTL and testbench
========================================

TDC_FINE_ENCODER_PIPE -- requirements
Module: tdc_fine_encoder_pipe

Interface
REQ-001 Parameter NTAP, default 21: number of delay-line/ring phase taps in the thermometer word.
REQ-002 Parameter OW, default 5: output code width; 2^OW SHALL exceed NTAP, and the all-ones code is reserved for error.
REQ-003 Parameter CNTW, default 16: error counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 din_valid  input  1  din qualifier, one sample per asserted cycle.
REQ-007 din  input  NTAP  circular thermometer code; bit i = tap i; tap NTAP-1 adjacent to tap 0.
REQ-008 level  input  2  mode: bit0 enables bubble filter, bit1 enables sticky error; sampled with din.
REQ-009 err_cnt_clr  input  1  synchronous clear of err_cnt and sticky error.
REQ-010 dout_valid  output  1  dout/err qualifier.
REQ-011 dout  output  OW  encoded fine phase 0..NTAP-1, or all ones on error.
REQ-012 err  output  1  invalid code for this sample (or sticky, per level[1]).
REQ-013 err_cnt  output  CNTW  saturating count of erroneous samples.

Function
REQ-014 Pipeline SHALL be 3 stages: S1 register din/level/din_valid; S2 filter + transition detect; S3 encode + error; dout_valid SHALL equal din_valid delayed exactly 3 cycles.
REQ-015 No stall: a new sample SHALL be accepted every cycle; bubbles (din_valid=0) SHALL propagate as dout_valid=0.
REQ-016 dout, err SHALL hold their last values while dout_valid=0.
REQ-017 Filter (level[0]=1): f[i] = majority(d[(i-1) mod NTAP], d[i], d[(i+1) mod NTAP]), circular; level[0]=0: f = d.
REQ-018 Rising transition at i: f[i]=1 and f[(i-1) mod NTAP]=0; wrap from tap NTAP-1 to tap 0 SHALL count.
REQ-019 Valid code: exactly one rising transition; dout = i of that transition.
REQ-020 Error: zero transitions (all zeros or all ones) or more than one transition; then dout = 2^OW-1, sample err=1.
REQ-021 err_cnt SHALL increment by 1 for each dout_valid cycle with sample err=1 and SHALL saturate at 2^CNTW-1.
REQ-022 level[1]=1: err output SHALL stay 1 after the first error until err_cnt_clr or reset; dout still per-sample.
REQ-023 err_cnt_clr same cycle as a counted error: clear wins, err_cnt=0 next cycle.
REQ-024 NTAP, OW, CNTW changes SHALL require no RTL edits; the transition search SHALL be a parametrised loop, not a fixed case table.

Reset
REQ-025 reset=1 SHALL immediately clear all pipeline valids, dout=0, err=0, err_cnt=0, sticky state=0.
REQ-026 Samples in flight at reset assertion SHALL be discarded; first dout_valid SHALL appear 3 cycles after the first din_valid following reset release.

Verification (NTAP=21, OW=5)
REQ-027 din=0x0000F0, level=0, one valid -> 3 cycles later dout_valid=1, dout=4, err=0, err_cnt=0.
REQ-028 Wrap: din bits {19,20,0,1} set -> dout=19, err=0.
REQ-029 Bubble: din bits {4,5,7,8}; level=1 -> dout=4, err=0; level=0 -> dout=31, err=1, err_cnt +1.
REQ-030 din=0 then din=0x1FFFFF, level=2, then clean code -> dout=31,31,valid code; err stays 1 on third; err_cnt=2; err_cnt_clr -> err=0, err_cnt=0.
REQ-031 Back-to-back 1000 random valid codes with random din_valid gaps -> every dout matches model, dout_valid count equals input count, latency 3.
REQ-032 Reset asserted with 2 samples in flight -> no dout_valid for them; CNTW=4 with 20 errors -> err_cnt=15.

Source files
------------

// File: rtl/tdc_fine_encoder_pipe.sv
// ---------------------------------------------------------------------------
// tdc_fine_encoder_pipe
//
// Three-stage pipelined fine-phase encoder for a TDC delay line or ring.
// A circular thermometer word (one bit per tap) is optionally bubble-filtered.
// Every rising 0->1 transition is then located, including the one that wraps
// from tap NTAP-1 to tap 0. If there is exactly one transition, its tap index
// is the output code. In every other case the code is all ones and the sample
// is flagged as an error. Erroneous samples are counted by a saturating
// counter. A sticky error view can be selected per sample.
//
// Pipeline:
//   S1 : register din / level / din_valid
//   S2 : bubble filter + rising-transition detect
//   S3 : transition encode, error flag, counter, sticky state
//
// Ports:
//   i_clk          : clock, all state on rising edge
//   i_rst          : asynchronous active-high reset
//   i_din_valid    : input sample qualifier (one sample per asserted cycle)
//   i_din          : circular thermometer code, bit i = tap i
//   i_level        : bit0 = bubble filter enable, bit1 = sticky error enable
//   i_err_cnt_clr  : synchronous clear of error counter and sticky state
//   o_dout_valid   : i_din_valid delayed by exactly 3 cycles
//   o_dout         : encoded tap index, or all ones on error (held when idle)
//   o_err          : sample error, or sticky error if level[1] was set
//   o_err_cnt      : saturating count of erroneous output samples
// ---------------------------------------------------------------------------
module tdc_fine_encoder_pipe #(
  parameter int NTAP = 21,
  parameter int OW   = 5,
  parameter int CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_din_valid,
  input  logic [NTAP-1:0] i_din,
  input  logic [1:0]      i_level,
  input  logic            i_err_cnt_clr,
  output logic            o_dout_valid,
  output logic [OW-1:0]   o_dout,
  output logic            o_err,
  output logic [CNTW-1:0] o_err_cnt
);

  // The all-ones code is reserved to mark an invalid sample.
  localparam logic [OW-1:0]   ERR_CODE = {OW{1'b1}};
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  // Majority of three neighbouring taps; this removes single-tap bubbles.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ------------------------------------------------------------------------
  // Stage 1 registers
  // ------------------------------------------------------------------------
  logic            r_s1_valid;
  logic [NTAP-1:0] r_s1_din;
  logic [1:0]      r_s1_level;

  // S1: capture the raw sample, its mode bits and its qualifier.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_din   <= {NTAP{1'b0}};
      r_s1_level <= 2'b00;
    end else begin
      r_s1_valid <= i_din_valid;
      r_s1_din   <= i_din;
      r_s1_level <= i_level;
    end
  end

  // ------------------------------------------------------------------------
  // Stage 2 logic: circular bubble filter and rising-transition detect
  // ------------------------------------------------------------------------
  logic [NTAP-1:0] w_filt;
  logic [NTAP-1:0] w_rise;

  // S2: neighbour majority filter; neighbours wrap around the ring.
  always_comb begin
    w_filt = r_s1_din;
    if (r_s1_level[0]) begin
      for (int i = 0; i < NTAP; i++) begin
        w_filt[i] = maj3(r_s1_din[(i + NTAP - 1) % NTAP],
                         r_s1_din[i],
                         r_s1_din[(i + 1) % NTAP]);
      end
    end else begin
      w_filt = r_s1_din;
    end
  end

  // S2: a rising transition at tap i means tap i is set and its lower
  // neighbour is clear. Tap 0's lower neighbour is tap NTAP-1.
  always_comb begin
    w_rise = {NTAP{1'b0}};
    for (int i = 0; i < NTAP; i++) begin
      w_rise[i] = w_filt[i] & ~w_filt[(i + NTAP - 1) % NTAP];
    end
  end

  logic            r_s2_valid;
  logic [NTAP-1:0] r_s2_rise;
  logic            r_s2_sticky_en;

  // S2: register the transition map together with its qualifier and mode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_valid     <= 1'b0;
      r_s2_rise      <= {NTAP{1'b0}};
      r_s2_sticky_en <= 1'b0;
    end else begin
      r_s2_valid     <= r_s1_valid;
      r_s2_rise      <= w_rise;
      r_s2_sticky_en <= r_s1_level[1];
    end
  end

  // ------------------------------------------------------------------------
  // Stage 3 logic: encode, error, counter, sticky
  // ------------------------------------------------------------------------
  logic [1:0]    w_ntrans;   // number of transitions, saturating at 2
  logic [OW-1:0] w_idx;      // tap index of the last transition found
  logic          w_err_s;    // this sample is invalid
  logic [OW-1:0] w_code;

  // S3: scan the transition map. Only zero, one or "more than one"
  // transitions have to be told apart, so the count saturates at 2.
  always_comb begin
    w_ntrans = 2'd0;
    w_idx    = {OW{1'b0}};
    for (int i = 0; i < NTAP; i++) begin
      if (r_s2_rise[i]) begin
        w_idx = OW'(i);
        if (w_ntrans != 2'd2) begin
          w_ntrans = w_ntrans + 2'd1;
        end else begin
          w_ntrans = 2'd2;
        end
      end else begin
        w_idx    = w_idx;
        w_ntrans = w_ntrans;
      end
    end
  end

  // S3: sample error flag and output code selection.
  always_comb begin
    w_err_s = (w_ntrans != 2'd1);
    if (w_err_s) begin
      w_code = ERR_CODE;
    end else begin
      w_code = w_idx;
    end
  end

  logic            r_sticky;    // an error was seen since the last clear
  logic            r_err_last;  // error flag of the most recent output sample
  logic [CNTW-1:0] r_err_cnt;

  // S3: output registers. dout/err only change on a valid output sample.
  // A clear while idle drops the sticky part of err and falls back to the
  // last sample's own error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dout_valid <= 1'b0;
      o_dout       <= {OW{1'b0}};
      o_err        <= 1'b0;
      r_err_last   <= 1'b0;
    end else begin
      o_dout_valid <= r_s2_valid;
      if (r_s2_valid) begin
        o_dout     <= w_code;
        r_err_last <= w_err_s;
        o_err      <= w_err_s | (r_s2_sticky_en & r_sticky & ~i_err_cnt_clr);
      end else if (i_err_cnt_clr) begin
        o_err      <= r_err_last;
      end else begin
        o_err      <= o_err;
      end
    end
  end

  // S3: saturating error counter and sticky flag; a clear beats a
  // simultaneous error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt <= {CNTW{1'b0}};
      r_sticky  <= 1'b0;
    end else if (i_err_cnt_clr) begin
      r_err_cnt <= {CNTW{1'b0}};
      r_sticky  <= 1'b0;
    end else if (r_s2_valid && w_err_s) begin
      r_sticky <= 1'b1;
      if (r_err_cnt != CNT_MAX) begin
        r_err_cnt <= r_err_cnt + CNTW'(1);
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end else begin
      r_err_cnt <= r_err_cnt;
      r_sticky  <= r_sticky;
    end
  end

  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_tdc_fine_encoder_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for tdc_fine_encoder_pipe (NTAP=21, OW=5).
// A second instance with CNTW=4 shares the stimulus and checks saturation.
// Expected values come from a reference model that works on whole samples:
// filtered tap array -> list of rising transitions -> code. A queue of
// expected output samples, tagged with their due cycle, also checks latency.
// ---------------------------------------------------------------------------
module tb_tdc_fine_encoder_pipe;

  localparam int NTAP = 21;
  localparam int OW   = 5;
  localparam int CNTW = 16;

  logic            clk;
  logic            rst;
  logic            din_valid;
  logic [NTAP-1:0] din;
  logic [1:0]      level;
  logic            clr;

  logic            dv;
  logic [OW-1:0]   dout;
  logic            err;
  logic [CNTW-1:0] cnt;

  logic            dv4;
  logic [OW-1:0]   dout4;
  logic            err4;
  logic [3:0]      cnt4;

  tdc_fine_encoder_pipe #(.NTAP(NTAP), .OW(OW), .CNTW(CNTW)) dut (
    .i_clk(clk), .i_rst(rst), .i_din_valid(din_valid), .i_din(din),
    .i_level(level), .i_err_cnt_clr(clr),
    .o_dout_valid(dv), .o_dout(dout), .o_err(err), .o_err_cnt(cnt)
  );

  tdc_fine_encoder_pipe #(.NTAP(NTAP), .OW(OW), .CNTW(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_din_valid(din_valid), .i_din(din),
    .i_level(level), .i_err_cnt_clr(clr),
    .o_dout_valid(dv4), .o_dout(dout4), .o_err(err4), .o_err_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int code;
    bit serr;
    bit lvl1;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   m_dout, m_cnt, m_cnt4;
  bit   m_err, m_last, m_sticky;
  int   n_in, n_obs;

  // Reference encoder: filter the ring, list every rising transition,
  // and accept only a sample with exactly one.
  function automatic void ref_encode(input logic [NTAP-1:0] d, input bit filt,
                                     output int code, output bit serr);
    bit f[NTAP];
    int rises[$];
    for (int i = 0; i < NTAP; i++) begin
      if (filt) begin
        int c = 0;
        if (d[(i + NTAP - 1) % NTAP]) c++;
        if (d[i]) c++;
        if (d[(i + 1) % NTAP]) c++;
        f[i] = (c >= 2);
      end else begin
        f[i] = d[i];
      end
    end
    for (int i = 0; i < NTAP; i++)
      if (f[i] && !f[(i + NTAP - 1) % NTAP]) rises.push_back(i);
    if (rises.size() == 1) begin
      code = rises[0];
      serr = 1'b0;
    end else begin
      code = (1 << OW) - 1;
      serr = 1'b1;
    end
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = 0; m_cnt = 0; m_cnt4 = 0;
    m_err = 1'b0; m_last = 1'b0; m_sticky = 1'b0;
  endtask

  // Advance the model by one clock edge and compare against both DUTs.
  task automatic model_check();
    bit   hit;
    exp_t e;
    hit = (q.size() > 0) && (q[0].due == cyc);
    chk_eq("dout_valid", dv, hit);
    chk_eq("dout_valid4", dv4, hit);
    if (dv) n_obs++;
    if (hit) begin
      e      = q.pop_front();
      m_dout = e.code;
      m_last = e.serr;
      m_err  = e.serr | (e.lvl1 & m_sticky & ~clr);
    end else if (clr) begin
      m_err = m_last;
    end
    if (clr) begin
      m_cnt = 0; m_cnt4 = 0; m_sticky = 1'b0;
    end else if (hit && e.serr) begin
      m_sticky = 1'b1;
      if (m_cnt < (1 << CNTW) - 1) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    chk_eq("dout", dout, m_dout);
    chk_eq("err", err, m_err);
    chk_eq("err_cnt", cnt, m_cnt);
    chk_eq("dout4", dout4, m_dout);
    chk_eq("err4", err4, m_err);
    chk_eq("err_cnt4", cnt4, m_cnt4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_check();
  endtask

  // Present one cycle of inputs and clock it in.
  task automatic drive(input bit v, input logic [NTAP-1:0] d, input logic [1:0] lv, input bit c);
    exp_t e;
    din_valid = v; din = d; level = lv; clr = c;
    if (v) begin
      ref_encode(d, lv[0], e.code, e.serr);
      e.lvl1 = lv[1];
      e.due  = cyc + 3;
      q.push_back(e);
      n_in++;
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, {NTAP{1'b0}}, 2'b00, 1'b0);
  endtask

  initial begin
    logic [NTAP-1:0] d;
    int s, len;
    rst = 1'b1; din_valid = 1'b0; din = '0; level = 2'b00; clr = 1'b0;
    cyc = 0; n_in = 0; n_obs = 0;
    model_reset();
    #12;
    chk_eq("rst_dv", dv, 1'b0);
    chk_eq("rst_dout", dout, 0);
    chk_eq("rst_err", err, 1'b0);
    chk_eq("rst_cnt", cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain thermometer, no filter.
    drive(1'b1, 21'h0000F0, 2'd0, 1'b0);
    idle(2);
    chk_eq("t_basic_dout", dout, 4);
    chk_eq("t_basic_err", err, 1'b0);
    chk_eq("t_basic_cnt", cnt, 0);

    // Transition that wraps from tap 20 to tap 0.
    drive(1'b1, 21'h180003, 2'd0, 1'b0);
    idle(2);
    chk_eq("t_wrap_dout", dout, 19);
    chk_eq("t_wrap_err", err, 1'b0);

    // Bubble: accepted with the filter, rejected without it.
    drive(1'b1, 21'h0001B0, 2'd1, 1'b0);
    idle(2);
    chk_eq("t_bub_f_dout", dout, 4);
    chk_eq("t_bub_f_err", err, 1'b0);
    drive(1'b1, 21'h0001B0, 2'd0, 1'b0);
    idle(2);
    chk_eq("t_bub_nf_dout", dout, 31);
    chk_eq("t_bub_nf_err", err, 1'b1);
    chk_eq("t_bub_nf_cnt", cnt, 1);

    // Sticky error sequence, then clear.
    drive(1'b0, '0, 2'd0, 1'b1);
    drive(1'b1, 21'h000000, 2'd2, 1'b0);
    drive(1'b1, 21'h1FFFFF, 2'd2, 1'b0);
    drive(1'b1, 21'h0000F0, 2'd2, 1'b0);
    idle(2);
    chk_eq("t_sticky_dout", dout, 4);
    chk_eq("t_sticky_err", err, 1'b1);
    chk_eq("t_sticky_cnt", cnt, 2);
    drive(1'b0, '0, 2'd0, 1'b1);
    chk_eq("t_clr_err", err, 1'b0);
    chk_eq("t_clr_cnt", cnt, 0);

    // Clear on the same cycle as a counted error: the clear wins.
    drive(1'b1, 21'h000000, 2'd0, 1'b0);
    idle(1);
    drive(1'b0, '0, 2'd0, 1'b1);
    chk_eq("t_clrwin_cnt", cnt, 0);

    // Saturation: 20 errors, narrow counter stops at 15.
    for (int k = 0; k < 20; k++) drive(1'b1, 21'h000000, 2'd0, 1'b0);
    idle(3);
    chk_eq("t_sat_cnt", cnt, 20);
    chk_eq("t_sat_cnt4", cnt4, 15);

    // Reset with two samples in flight: both must vanish.
    drive(1'b1, 21'h0000F0, 2'd0, 1'b0);
    drive(1'b1, 21'h000FF0, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk_eq("t_arst_dv", dv, 1'b0);
    chk_eq("t_arst_dout", dout, 0);
    chk_eq("t_arst_cnt", cnt, 0);
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(4);

    // Random traffic with gaps, occasional clears and raw (mostly bad) words.
    n_in = 0; n_obs = 0;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 9) < 3) begin
        drive(1'b0, NTAP'($urandom()), 2'($urandom()), ($urandom_range(0, 49) == 0));
      end else begin
        if ($urandom_range(0, 4) == 0) begin
          d = NTAP'($urandom());
        end else begin
          s   = $urandom_range(0, NTAP - 1);
          len = $urandom_range(1, NTAP - 1);
          d   = '0;
          for (int b = 0; b < len; b++) d[(s + b) % NTAP] = 1'b1;
        end
        drive(1'b1, d, 2'($urandom()), ($urandom_range(0, 49) == 0));
      end
    end
    idle(4);
    chk_eq("rand_count", n_obs, n_in);
    chk_eq("rand_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
